// File: rtl/wb_forward_stage.sv
// wb_forward_stage: writeback mux with load formatting, plus a forwarding
// lookup for two source registers.
//
// Optional feature: define WB_HIST_FWD_EN to add a HIST_DEPTH-entry history
// of retired writebacks that the lookups also search. Without the macro the
// block is purely combinational, and stall/flush have no effect.
//
// Ports:
//   clk, rst            clock, async active-high reset (history only)
//   stall, flush        hold / invalidate history
//   MEM_WB_*            writeback-stage inputs (rd, RegWrite, Mem2Reg,
//                       ALU result, PC link value, raw load word, funct3,
//                       load byte offset)
//   ID_rs1, ID_rs2      source registers to look up
//   WB_rd, WB_RegWrite, WB_wdata   regfile write port (combinational)
//   fwd_rs{1,2}_hit/_data          forwarding results (combinational)
module wb_forward_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RADDR      = 5,
    parameter int unsigned HIST_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [RADDR-1:0] MEM_WB_rd,
    input  logic             MEM_WB_RegWrite,
    input  logic [1:0]       MEM_WB_Mem2Reg,
    input  logic [XLEN-1:0]  MEM_WB_ALU_Result,
    input  logic [XLEN-1:0]  MEM_WB_PC,
    input  logic [XLEN-1:0]  MEM_WB_ReadData,
    input  logic [2:0]       MEM_WB_funct3,
    input  logic [1:0]       MEM_WB_addr_lo,
    input  logic [RADDR-1:0] ID_rs1,
    input  logic [RADDR-1:0] ID_rs2,
    output logic [RADDR-1:0] WB_rd,
    output logic             WB_RegWrite,
    output logic [XLEN-1:0]  WB_wdata,
    output logic             fwd_rs1_hit,
    output logic [XLEN-1:0]  fwd_rs1_data,
    output logic             fwd_rs2_hit,
    output logic [XLEN-1:0]  fwd_rs2_data
);

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    // Load lane select and extension
    always_comb begin
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        ld_data = MEM_WB_ReadData;
        case (MEM_WB_addr_lo)
            2'd0:    ld_byte = MEM_WB_ReadData[7:0];
            2'd1:    ld_byte = MEM_WB_ReadData[15:8];
            2'd2:    ld_byte = MEM_WB_ReadData[23:16];
            default: ld_byte = MEM_WB_ReadData[31:24];
        endcase
        ld_half = MEM_WB_addr_lo[1] ? MEM_WB_ReadData[31:16] : MEM_WB_ReadData[15:0];
        case (MEM_WB_funct3)
            3'b000:  ld_data = XLEN'($signed(ld_byte));
            3'b001:  ld_data = XLEN'($signed(ld_half));
            3'b010:  ld_data = XLEN'($signed(MEM_WB_ReadData[31:0]));
            3'b100:  ld_data = XLEN'(ld_byte);
            3'b101:  ld_data = XLEN'(ld_half);
            default: ld_data = MEM_WB_ReadData;
        endcase
    end

    // Writeback source select
    always_comb begin
        WB_wdata = MEM_WB_ALU_Result;
        case (MEM_WB_Mem2Reg)
            2'b01:   WB_wdata = ld_data;
            2'b10:   WB_wdata = MEM_WB_PC;
            default: WB_wdata = MEM_WB_ALU_Result;
        endcase
    end

    // x0 is never written
    assign WB_rd       = MEM_WB_rd;
    assign WB_RegWrite = MEM_WB_RegWrite && (MEM_WB_rd != '0);

`ifdef WB_HIST_FWD_EN
    logic             hist_valid [HIST_DEPTH];
    logic [RADDR-1:0] hist_rd    [HIST_DEPTH];
    logic [XLEN-1:0]  hist_data  [HIST_DEPTH];

    // History shift register; entry 0 is the newest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                hist_valid[i] <= 1'b0;
                hist_rd[i]    <= '0;
                hist_data[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                hist_valid[i] <= 1'b0;
            end
        end else if (!stall) begin
            for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) begin
                hist_valid[i] <= hist_valid[i-1];
                hist_rd[i]    <= hist_rd[i-1];
                hist_data[i]  <= hist_data[i-1];
            end
            hist_valid[0] <= WB_RegWrite;
            hist_rd[0]    <= WB_rd;
            hist_data[0]  <= WB_wdata;
        end
    end
`else
    wire unused_hist_inputs = ^{clk, rst, stall, flush};
`endif

    // Returns {hit, data}; scanned oldest-first so younger sources overwrite
    function automatic logic [XLEN:0] lookup(input logic [RADDR-1:0] rs);
        logic [XLEN:0] r;
        r = '0;
`ifdef WB_HIST_FWD_EN
        for (int i = int'(HIST_DEPTH) - 1; i >= 0; i--) begin
            if (hist_valid[i] && (hist_rd[i] == rs)) r = {1'b1, hist_data[i]};
        end
`endif
        if (WB_RegWrite && (WB_rd == rs)) r = {1'b1, WB_wdata};
        if (rs == '0) r = '0;
        return r;
    endfunction

    assign {fwd_rs1_hit, fwd_rs1_data} = lookup(ID_rs1);
    assign {fwd_rs2_hit, fwd_rs2_data} = lookup(ID_rs2);

endmodule

// File: tb/tb_wb_forward_stage.sv
module tb_wb_forward_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned RADDR = 5;
`ifdef WB_HIST_FWD_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, stall, flush;
    logic [RADDR-1:0] MEM_WB_rd;
    logic             MEM_WB_RegWrite;
    logic [1:0]       MEM_WB_Mem2Reg;
    logic [XLEN-1:0]  MEM_WB_ALU_Result, MEM_WB_PC, MEM_WB_ReadData;
    logic [2:0]       MEM_WB_funct3;
    logic [1:0]       MEM_WB_addr_lo;
    logic [RADDR-1:0] ID_rs1, ID_rs2;
    logic [RADDR-1:0] WB_rd;
    logic             WB_RegWrite;
    logic [XLEN-1:0]  WB_wdata;
    logic             fwd_rs1_hit, fwd_rs2_hit;
    logic [XLEN-1:0]  fwd_rs1_data, fwd_rs2_data;

    int passes = 0;
    int total  = 0;

    wb_forward_stage #(.XLEN(XLEN), .RADDR(RADDR), .HIST_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_Mem2Reg(MEM_WB_Mem2Reg), .MEM_WB_ALU_Result(MEM_WB_ALU_Result),
        .MEM_WB_PC(MEM_WB_PC), .MEM_WB_ReadData(MEM_WB_ReadData),
        .MEM_WB_funct3(MEM_WB_funct3), .MEM_WB_addr_lo(MEM_WB_addr_lo),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite), .WB_wdata(WB_wdata),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_data(fwd_rs1_data),
        .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_data(fwd_rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [RADDR-1:0] rd, input logic we, input logic [XLEN-1:0] alu);
        MEM_WB_rd         = rd;
        MEM_WB_RegWrite   = we;
        MEM_WB_Mem2Reg    = 2'b00;
        MEM_WB_ALU_Result = alu;
    endtask

    task automatic set_load(input logic [2:0] f3, input logic [1:0] lo);
        MEM_WB_Mem2Reg = 2'b01;
        MEM_WB_funct3  = f3;
        MEM_WB_addr_lo = lo;
        #1;
    endtask

    // Two back-to-back writes to x5, then idle: the younger value must win
    task automatic youngest_wins(input string tag);
        set_wb(5'd5, 1'b1, 32'hA);
        tick();
        set_wb(5'd5, 1'b1, 32'hB);
        ID_rs1 = 5'd5;
        #1;
        check({tag, "_cur_data"}, 64'(fwd_rs1_data), 64'hB);
        tick();
        set_wb(5'd0, 1'b0, 32'h0);
        #1;
        check({tag, "_hit"},  64'(fwd_rs1_hit),  64'(HIST));
        check({tag, "_data"}, 64'(fwd_rs1_data), HIST ? 64'hB : 64'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        MEM_WB_rd = '0; MEM_WB_RegWrite = 1'b0; MEM_WB_Mem2Reg = 2'b00;
        MEM_WB_ALU_Result = '0; MEM_WB_PC = '0; MEM_WB_ReadData = '0;
        MEM_WB_funct3 = 3'b000; MEM_WB_addr_lo = 2'd0;
        ID_rs1 = 5'd5; ID_rs2 = 5'd6;
        #12;
        check("rst_wb_we", 64'(WB_RegWrite), 64'h0);
        check("rst_rs1_hit", 64'(fwd_rs1_hit), 64'h0);
        check("rst_rs1_data", 64'(fwd_rs1_data), 64'h0);

        // Current-WB hit is visible even while in reset
        set_wb(5'd5, 1'b1, 32'h1234);
        #1;
        check("rst_cur_hit", 64'(fwd_rs1_hit), 64'h1);
        check("rst_cur_data", 64'(fwd_rs1_data), 64'h1234);
        check("rst_rs2_miss", 64'(fwd_rs2_hit), 64'h0);
        set_wb(5'd0, 1'b0, 32'h0);

        // Load formatting
        MEM_WB_ReadData = 32'h1280_3456;
        set_load(3'b000, 2'd2); check("lb_lo2", 64'(WB_wdata), 64'hFFFF_FF80);
        set_load(3'b100, 2'd2); check("lbu_lo2", 64'(WB_wdata), 64'h0000_0080);
        set_load(3'b000, 2'd3); check("lb_lo3", 64'(WB_wdata), 64'h0000_0012);
        set_load(3'b000, 2'd1); check("lb_lo1", 64'(WB_wdata), 64'h0000_0034);
        set_load(3'b010, 2'd0); check("lw", 64'(WB_wdata), 64'h1280_3456);
        set_load(3'b011, 2'd1); check("f3_other", 64'(WB_wdata), 64'h1280_3456);
        MEM_WB_ReadData = 32'h8000_7FFF;
        set_load(3'b001, 2'd0); check("lh_lo0", 64'(WB_wdata), 64'h0000_7FFF);
        set_load(3'b001, 2'd2); check("lh_lo2", 64'(WB_wdata), 64'hFFFF_8000);
        set_load(3'b101, 2'd2); check("lhu_lo2", 64'(WB_wdata), 64'h0000_8000);
        set_load(3'b000, 2'd0); check("lb_lo0", 64'(WB_wdata), 64'hFFFF_FFFF);

        // Writeback source select
        MEM_WB_ReadData = 32'h1280_3456;
        MEM_WB_ALU_Result = 32'h1111; MEM_WB_PC = 32'h2222;
        MEM_WB_Mem2Reg = 2'b00; #1; check("sel00", 64'(WB_wdata), 64'h1111);
        MEM_WB_Mem2Reg = 2'b01; #1; check("sel01", 64'(WB_wdata), 64'h56);
        MEM_WB_Mem2Reg = 2'b10; #1; check("sel10", 64'(WB_wdata), 64'h2222);
        MEM_WB_Mem2Reg = 2'b11; #1; check("sel11", 64'(WB_wdata), 64'h1111);

        // Formatted load data is what gets forwarded
        MEM_WB_rd = 5'd6; MEM_WB_RegWrite = 1'b1;
        set_load(3'b000, 2'd2);
        check("fwd_load_hit", 64'(fwd_rs2_hit), 64'h1);
        check("fwd_load_data", 64'(fwd_rs2_data), 64'hFFFF_FF80);

        // Writes to x0 are suppressed and x0 never hits
        set_wb(5'd0, 1'b1, 32'h99);
        ID_rs2 = 5'd0;
        #1;
        check("x0_we", 64'(WB_RegWrite), 64'h0);
        check("x0_rd", 64'(WB_rd), 64'h0);
        check("x0_hit", 64'(fwd_rs2_hit), 64'h0);
        check("x0_data", 64'(fwd_rs2_data), 64'h0);
        set_wb(5'd0, 1'b0, 32'h0);
        ID_rs2 = 5'd6;

        @(negedge clk);
        rst = 1'b0;
        youngest_wins("young");

        // Async reset between edges drops history hits at once
        #2;
        rst = 1'b1;
        #1;
        check("arst_hit", 64'(fwd_rs1_hit), 64'h0);
        check("arst_data", 64'(fwd_rs1_data), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        youngest_wins("young2");

        // Flush together with stall
        set_wb(5'd10, 1'b1, 32'h10); tick();
        set_wb(5'd11, 1'b1, 32'h11); tick();
        set_wb(5'd9, 1'b1, 32'h99);
        ID_rs1 = 5'd10; ID_rs2 = 5'd11;
        flush = 1'b1; stall = 1'b1;
        #1;
        check("preflush_hit", 64'(fwd_rs2_hit), 64'(HIST));
        tick();
        flush = 1'b0; stall = 1'b0;
        #1;
        check("flush_rs1_miss", 64'(fwd_rs1_hit), 64'h0);
        check("flush_rs2_miss", 64'(fwd_rs2_hit), 64'h0);
        ID_rs1 = 5'd9;
        #1;
        check("flush_cur_hit", 64'(fwd_rs1_hit), 64'h1);
        check("flush_cur_data", 64'(fwd_rs1_data), 64'h99);
        MEM_WB_RegWrite = 1'b0;
        #1;
        check("flush_noload", 64'(fwd_rs1_hit), 64'h0);

        // Stall holds history; a stalled write enters history exactly once
        set_wb(5'd3, 1'b1, 32'h33); tick();
        set_wb(5'd7, 1'b1, 32'h55);
        stall = 1'b1;
        ID_rs1 = 5'd3; ID_rs2 = 5'd7;
        tick(); tick(); tick();
        check("stall_hold_x3", 64'(fwd_rs1_data), HIST ? 64'h33 : 64'h0);
        check("stall_cur_x7", 64'(fwd_rs2_data), 64'h55);
        stall = 1'b0;
        tick();
        set_wb(5'd0, 1'b0, 32'h0);
        ID_rs1 = 5'd7; ID_rs2 = 5'd3;
        #1;
        check("unstall_x7_e0", 64'(fwd_rs1_data), HIST ? 64'h55 : 64'h0);
        check("unstall_x3_e1", 64'(fwd_rs2_data), HIST ? 64'h33 : 64'h0);
        tick();
        check("shift_x7_e1", 64'(fwd_rs1_hit), 64'(HIST));
        check("shift_x3_gone", 64'(fwd_rs2_hit), 64'h0);
        tick();
        check("x7_single_copy", 64'(fwd_rs1_hit), 64'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/wb_forward_stage.md
WB_FORWARD_STAGE -- requirements
Module: wb_forward_stage

Interface
- REQ-001 SHALL have parameter XLEN, default 32: datapath width in bits; legal values are 32 and 64.
- REQ-002 SHALL have parameter RADDR, default 5: register-address width.
- REQ-003 SHALL have parameter HIST_DEPTH, default 2 (minimum 1): number of retired-writeback history entries.
- REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports are clk and rst.
- REQ-005 SHALL have ports:
  - clk  in  1  clock
  - rst  in  1  async active-high reset
  - stall  in  1  hold history
  - flush  in  1  invalidate history
  - MEM_WB_rd  in  RADDR  destination register
  - MEM_WB_RegWrite  in  1  write request
  - MEM_WB_Mem2Reg  in  2  writeback source select
  - MEM_WB_ALU_Result  in  XLEN  ALU result
  - MEM_WB_PC  in  XLEN  link value
  - MEM_WB_ReadData  in  XLEN  raw load word
  - MEM_WB_funct3  in  3  load type
  - MEM_WB_addr_lo  in  2  load byte offset
  - ID_rs1  in  RADDR  source register 1
  - ID_rs2  in  RADDR  source register 2
  - WB_rd  out  RADDR  regfile write address
  - WB_RegWrite  out  1  regfile write enable
  - WB_wdata  out  XLEN  regfile write data
  - fwd_rs1_hit  out  1  rs1 forward hit
  - fwd_rs1_data  out  XLEN  rs1 forward data
  - fwd_rs2_hit  out  1  rs2 forward hit
  - fwd_rs2_data  out  XLEN  rs2 forward data

Function
- REQ-006 SHALL drive WB_wdata combinationally with zero latency, selected by MEM_WB_Mem2Reg:
  - 00: ALU_Result
  - 01: formatted load
  - 10: PC
  - 11: ALU_Result
- REQ-007 SHALL format loads by funct3, selecting the lane with addr_lo:
  - 000 LB: byte addr_lo, sign-extended to XLEN
  - 001 LH: half addr_lo[1], sign-extended
  - 010 LW: low word, sign-extended
  - 100 LBU / 101 LHU: zero-extended
  - any other funct3: ReadData unchanged
- REQ-008 SHALL drive WB_rd = MEM_WB_rd and WB_RegWrite = MEM_WB_RegWrite AND (MEM_WB_rd != 0).
- REQ-009 SHALL hold HIST_DEPTH entries of {valid, rd, data}; entry 0 is the newest.
- REQ-010 On a clk rising edge with flush=0 and stall=0, SHALL shift entry i into entry i+1, drop the oldest entry, and load entry 0 with {WB_RegWrite, WB_rd, WB_wdata}.
- REQ-011 On a rising edge with stall=1 and flush=0, SHALL hold all history entries unchanged.
- REQ-012 On a rising edge with flush=1, SHALL clear every valid bit, regardless of stall; rd and data fields are don't-care.
- REQ-013 SHALL compute each lookup combinationally from these sources, in priority order:
  - current WB (WB_RegWrite=1 and WB_rd==rs)
  - entry 0 through entry HIST_DEPTH-1; the first valid match wins
- REQ-014 On a lookup hit, SHALL assert hit=1 with the winning data; on a miss, hit=0 and data=0.
- REQ-015 SHALL never report a hit for rs==0.
- REQ-016 SHALL resolve duplicate rd values to the youngest source.

Reset
- REQ-017 While rst=1, SHALL asynchronously clear all history valid bits, rd fields and data fields to 0.
- REQ-018 After reset, SHALL report a hit only from the current WB stage until the first enabled clock edge.
- REQ-019 SHALL give reset priority over flush and stall; a reset asserted mid-stall discards held entries.

Configuration
- REQ-020 SHALL use macro WB_HIST_FWD_EN to compile in the history buffer and history lookups.
- REQ-021 Without WB_HIST_FWD_EN:
  - no history registers exist
  - stall and flush are ignored
  - forwarding hits come only from the current WB stage
  - the block is purely combinational

Verification
- REQ-022 Mem2Reg=01, funct3=000, addr_lo=2, ReadData=0x12_80_34_56 -> WB_wdata=0xFFFFFF80; the same input with funct3=100 -> 0x00000080.
- REQ-023 Writes x5=0xA, then x5=0xB, then idle; ID_rs1=5 -> fwd_rs1_data=0xB, hit=1 (youngest entry wins).
- REQ-024 Write x7=0x55 with stall=1 for 3 cycles, then stall=0 -> exactly one entry 0 holds x7 and entry 1 does not hold x7.
- REQ-025 Fill history, then pulse flush together with stall -> all lookups miss next cycle; the current-WB hit is still reported.
- REQ-026 MEM_WB_rd=0, RegWrite=1, ALU=0x99 -> WB_RegWrite=0; ID_rs2=0 -> fwd_rs2_hit=0, data=0.
- REQ-027 Assert rst asynchronously between edges with valid history -> all hits drop immediately; re-run REQ-023 after deassertion and pass.
